// File: rtl/imem_pkg.sv
// Shared definitions for the instruction memory and its loader: capacity,
// framing constants and the loader state encoding.
package imem_pkg;

  localparam int IMEM_DEPTH_WORDS = 256;
  localparam int HDR_BYTES        = 4;
  localparam int WORD_BYTES       = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_DATA,
    ST_DONE,
    ST_ERR
  } load_state_e;

endpackage

// File: rtl/imem_byte_packer.sv
// Little-endian byte-to-word assembler. The 4th byte bypasses the assembly
// register so the finished word is available on the accepting edge.
module imem_byte_packer
  import imem_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_data,
  output logic        word_valid,
  output logic [31:0] word
);

  localparam logic [1:0] LAST_BYTE = 2'(WORD_BYTES - 1);

  logic [1:0]  byte_cnt;
  logic [23:0] partial;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt <= '0;
      partial  <= '0;
    end else if (clear) begin
      byte_cnt <= '0;
      partial  <= '0;
    end else if (byte_en) begin
      byte_cnt <= byte_cnt + 2'd1;
      case (byte_cnt)
        2'd0:    partial[7:0]   <= byte_data;
        2'd1:    partial[15:8]  <= byte_data;
        2'd2:    partial[23:16] <= byte_data;
        default: ;
      endcase
    end
  end

  assign word_valid = byte_en && !clear && (byte_cnt == LAST_BYTE);
  assign word       = {byte_data, partial};

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed program image from a byte stream into instruction
// memory and holds the CPU in reset until the image is complete.
module imem_loader
  import imem_pkg::*;
#(
  parameter int          DEPTH_WORDS = IMEM_DEPTH_WORDS,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  output logic             byte_ready,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic             cpu_hold,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] words_loaded
);

  load_state_e      state_q, state_d;
  logic             byte_en;
  logic             word_valid;
  logic [31:0]      word;
  logic [CNT_W-1:0] n_words;
  logic [CNT_W-1:0] hdr_count;
  logic             last_word;

  assign byte_en   = byte_valid && byte_ready;
  assign hdr_count = word[CNT_W-1:0];
  // words_loaded doubles as the write index: it equals the index of the next word.
  assign last_word = (words_loaded + CNT_W'(1)) == n_words;

  imem_byte_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (start),
    .byte_en    (byte_en),
    .byte_data  (byte_data),
    .word_valid (word_valid),
    .word       (word)
  );

  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_HDR: begin
        if (word_valid) begin
          if (hdr_count == '0)
            state_d = ST_DONE;
          else if (32'(hdr_count) > 32'(DEPTH_WORDS))
            state_d = ST_ERR;
          else
            state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (word_valid && last_word)
          state_d = ST_DONE;
      end
      default: ;
    endcase
    if (start)
      state_d = ST_HDR;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      byte_ready   <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= BASE_ADDR;
      mem_wdata    <= '0;
      cpu_hold     <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
      n_words      <= '0;
    end else begin
      state_q    <= state_d;
      byte_ready <= (state_d == ST_HDR) || (state_d == ST_DATA);
      if (start) begin
        // A write issued on the previous edge is already on the port and completes.
        mem_we       <= 1'b0;
        cpu_hold     <= 1'b1;
        done         <= 1'b0;
        error        <= 1'b0;
        words_loaded <= '0;
        n_words      <= '0;
      end else begin
        mem_we   <= (state_q == ST_DATA) && word_valid;
        done     <= (state_q == ST_DONE);
        error    <= (state_q == ST_ERR);
        cpu_hold <= (state_q != ST_DONE);
        if (state_q == ST_HDR && word_valid)
          n_words <= hdr_count;
        if (state_q == ST_DATA && word_valid) begin
          mem_addr     <= BASE_ADDR + (32'(words_loaded) << 2);
          mem_wdata    <= word;
          words_loaded <= words_loaded + CNT_W'(1);
        end
      end
    end
  end

endmodule
